// File: rtl/aes_lastround_pipe.sv
`default_nettype none
// ============================================================================
// Module   : aes_lastround_pipe
// Brief    : Elastic-pipelined AES final round (encrypt and optional decrypt).
// Revision : 1.0
// ============================================================================
module aes_lastround_pipe #(
    parameter int NR          = 10,
    parameter int KEY_W       = 128 * (NR + 1),
    parameter int PIPE_STAGES = 1,
    parameter bit DECRYPT_EN  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [127:0]     state,
    input  logic [KEY_W-1:0] key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out,
    output logic             busy
);

    localparam int c_LAST = PIPE_STAGES - 1;
    localparam int c_MID  = (PIPE_STAGES >= 2) ? PIPE_STAGES - 2 : 0;

    if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
        $error("aes_lastround_pipe: NR must be 10, 12 or 14");
    end
    if (PIPE_STAGES < 1 || PIPE_STAGES > 3) begin : g_bad_stages
        $error("aes_lastround_pipe: PIPE_STAGES must be 1..3");
    end
    if (KEY_W != 128 * (NR + 1)) begin : g_bad_keyw
        $error("aes_lastround_pipe: KEY_W must not be overridden");
    end

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; a^127 is built by six square-and-multiply steps.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] t;
        t = a;
        for (int i = 0; i < 6; i++) t = gmul(gmul(t, t), a);
        return gmul(t, t);
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] y;
        y = ginv(x);
        return y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return ginv(rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05);
    endfunction

    // Byte n of the block sits at bits [127-8n -: 8], with n = row + 4*column.
    function automatic logic [127:0] enc_path(input logic [127:0] s);
        logic [127:0] r;
        int src;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                src = (c + row) % 4;
                r[127 - 8*(4*c + row) -: 8] = sbox(s[127 - 8*(4*src + row) -: 8]);
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] dec_path(input logic [127:0] s);
        logic [127:0] r;
        int src;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                src = (c + 4 - row) % 4;
                r[127 - 8*(4*c + row) -: 8] = inv_sbox(s[127 - 8*(4*src + row) -: 8]);
            end
        end
        return r;
    endfunction

    logic [PIPE_STAGES-1:0] r_v;
    logic [PIPE_STAGES-1:0] w_load;
    logic [PIPE_STAGES-1:0] w_vin;
    logic [PIPE_STAGES-1:0] w_fire;

    // A stage may load when empty or when everything downstream of it moves.
    always_comb begin
        logic w_nxt;
        w_nxt    = out_ready;
        w_load   = '0;
        w_vin    = '0;
        w_vin[0] = in_valid;
        for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
            w_nxt     = !r_v[k] || w_nxt;
            w_load[k] = w_nxt;
        end
        for (int k = 1; k < PIPE_STAGES; k++) begin
            w_vin[k] = r_v[k-1];
        end
    end

    assign w_fire = w_load & w_vin;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v <= '0;
        end else begin
            r_v <= (w_load & w_vin) | (~w_load & r_v);
        end
    end

    assign in_ready  = w_load[0];
    assign out_valid = r_v[c_LAST];
    assign busy      = |r_v;

    logic         w_in_mode;
    logic [127:0] w_in_rk;
    assign w_in_mode = DECRYPT_EN ? mode : 1'b0;
    assign w_in_rk   = w_in_mode ? key[KEY_W-1 -: 128] : key[127:0];

    logic [127:0] w_a_state;
    logic [127:0] w_a_rk;
    logic         w_a_mode;
    logic [127:0] w_sub;
    logic [127:0] w_b_data;
    logic [127:0] w_b_rk;

    if (PIPE_STAGES == 3) begin : g_in_reg
        logic [127:0] r_state;
        logic [127:0] r_rk;
        logic         r_mode;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_state <= '0;
                r_rk    <= '0;
                r_mode  <= 1'b0;
            end else if (w_fire[0]) begin
                r_state <= state;
                r_rk    <= w_in_rk;
                r_mode  <= w_in_mode;
            end
        end
        assign w_a_state = r_state;
        assign w_a_rk    = r_rk;
        assign w_a_mode  = r_mode;
    end else begin : g_in_bypass
        assign w_a_state = state;
        assign w_a_rk    = w_in_rk;
        assign w_a_mode  = w_in_mode;
    end

    if (DECRYPT_EN) begin : g_dec
        assign w_sub = w_a_mode ? dec_path(w_a_state) : enc_path(w_a_state);
    end else begin : g_enc_only
        assign w_sub = enc_path(w_a_state);
    end

    if (PIPE_STAGES >= 2) begin : g_mid_reg
        logic [127:0] r_data;
        logic [127:0] r_rk;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_data <= '0;
                r_rk   <= '0;
            end else if (w_fire[c_MID]) begin
                r_data <= w_sub;
                r_rk   <= w_a_rk;
            end
        end
        assign w_b_data = r_data;
        assign w_b_rk   = r_rk;
    end else begin : g_mid_bypass
        assign w_b_data = w_sub;
        assign w_b_rk   = w_a_rk;
    end

    logic [127:0] r_out;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out <= '0;
        end else if (w_fire[c_LAST]) begin
            r_out <= w_b_data ^ w_b_rk;
        end
    end
    assign out = r_out;

    // Intermediate round keys never reach the datapath.
    logic w_unused;
    assign w_unused = ^{key[KEY_W-129:128], mode, w_a_mode};

endmodule
`default_nettype wire

// File: tb/tb_aes_lastround_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_lastround_pipe
// Brief    : Scoreboard bench for four aes_lastround_pipe configurations.
// Revision : 1.0
// ============================================================================
module tb_aes_lastround_pipe;

    localparam int N = 4;
    localparam int c_NR [N] = '{10, 10, 14, 12};
    localparam int c_PS [N] = '{1, 3, 2, 2};
    localparam bit c_DE [N] = '{1'b1, 1'b1, 1'b1, 1'b0};

    localparam logic [127:0] c_B_ST   = 128'heb40f21e592e38848ba113e71bc342d2;
    localparam logic [127:0] c_B_RK   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] c_B_EXP  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] c_D_ST   = 128'h6353e08c0960e104cd70b751bacad0e7;
    localparam logic [127:0] c_D_RK   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_D_EXP  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_C_ST   = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
    localparam logic [127:0] c_C_RK   = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] c_C_EXP  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic          clk = 1'b0;
    logic          rst;
    int            cyc = 0;
    logic          in_valid  [N];
    logic          in_ready  [N];
    logic          mode      [N];
    logic          out_valid [N];
    logic          out_ready [N];
    logic          busy      [N];
    logic [127:0]  st        [N];
    logic [127:0]  out_d     [N];
    logic [1919:0] key       [N];

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [127:0]  exp_q     [N][$];
    int            acc_cyc   [N];
    int            bp_mode   [N];
    int            bp_base   = 0;
    bit            stall_seen[N];
    bit            hold_pend [N];
    logic [127:0]  hold_val  [N];
    logic [7:0]    sbox      [256];
    logic [7:0]    isbox     [256];

    for (genvar g = 0; g < N; g++) begin : g_dut
        aes_lastround_pipe #(
            .NR         (c_NR[g]),
            .PIPE_STAGES(c_PS[g]),
            .DECRYPT_EN (c_DE[g])
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .mode     (mode[g]),
            .state    (st[g]),
            .key      (key[g][128*(c_NR[g]+1)-1:0]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out      (out_d[g]),
            .busy     (busy[g])
        );
    end

    initial forever begin
        #5 clk = 1'b1;
        cyc++;
        #5 clk = 1'b0;
    end

    task automatic chk(input int id, input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h expected %h", nm, id, act, exp);
        end
    endtask

    // Reference tables from GF(2^8) log/antilog (generator 0x03) and the affine map.
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    task automatic build_tables();
        logic [7:0] alog [255];
        int         lg   [256];
        logic [7:0] p, inv, s, cv;
        p  = 8'h01;
        cv = 8'h63;
        for (int i = 0; i < 255; i++) begin
            alog[i] = p;
            lg[p]   = i;
            p       = p ^ xt(p);
        end
        for (int x = 0; x < 256; x++) begin
            inv = (x == 0) ? 8'h00 : alog[(255 - lg[x]) % 255];
            for (int b = 0; b < 8; b++)
                s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ cv[b];
            sbox[x]  = s;
            isbox[s] = x[7:0];
        end
    endtask

    function automatic logic [127:0] ref_out(input int id, input logic [127:0] s, input logic md,
                                             input logic [1919:0] k);
        logic [1919:0] sh;
        logic [127:0]  rk, r;
        logic [7:0]    b;
        int            kw, idx, src;
        logic          dec;
        dec = md && c_DE[id];
        kw  = 128 * (c_NR[id] + 1);
        idx = dec ? 0 : c_NR[id];
        sh  = k >> (kw - 128 * (idx + 1));
        rk  = sh[127:0];
        r   = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                src = dec ? (c - row + 4) % 4 : (c + row) % 4;
                b   = s[127 - 8*(4*src + row) -: 8];
                r[127 - 8*(4*c + row) -: 8] = (dec ? isbox[b] : sbox[b]) ^ rk[127 - 8*(4*c + row) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [1919:0] rand_key();
        logic [1919:0] k;
        for (int i = 0; i < 60; i++) k[32*i +: 32] = $urandom;
        return k;
    endfunction

    function automatic logic [127:0] rand_blk();
        logic [127:0] v;
        for (int i = 0; i < 4; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // Drive at posedge+1; accept is decided by in_ready seen at the following negedge.
    task automatic send(input int id, input logic [127:0] s, input logic md,
                        input logic [1919:0] k, input logic [127:0] exp);
        bit acc;
        int waited;
        acc    = 1'b0;
        waited = 0;
        st[id] = s; mode[id] = md; key[id] = k; in_valid[id] = 1'b1;
        while (!acc) begin
            @(negedge clk);
            if (in_ready[id]) begin
                acc = 1'b1;
                exp_q[id].push_back(exp);
                acc_cyc[id] = cyc;
            end else begin
                stall_seen[id] = 1'b1;
            end
            @(posedge clk); #1;
            waited++;
            if (!acc && waited > 500) begin
                chk(id, "accept_timeout", 128'(in_ready[id]), 128'd1);
                break;
            end
        end
        in_valid[id] = 1'b0;
        key[id]      = rand_key();
        st[id]       = rand_blk();
        mode[id]     = $urandom_range(0, 1) == 1;
    endtask

    task automatic wait_lat(input int id);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid[id] && n < 50);
        chk(id, "latency", 128'(cyc - acc_cyc[id]), 128'(c_PS[id]));
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0 && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_rand(input int id, input int nblk);
        logic [127:0]  s;
        logic [1919:0] k;
        logic          md;
        for (int j = 0; j < nblk; j++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            s  = rand_blk();
            k  = rand_key();
            md = $urandom_range(0, 1) == 1;
            send(id, s, md, k, ref_out(id, s, md, k));
        end
    endtask

    initial forever begin
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin
            case (bp_mode[i])
                0:       out_ready[i] = 1'b1;
                1:       out_ready[i] = $urandom_range(0, 3) != 0;
                2:       out_ready[i] = 1'b0;
                default: out_ready[i] = !((cyc - bp_base) >= 4 && (cyc - bp_base) <= 7);
            endcase
        end
    end

    // Monitor: pops on every handshake, and checks outputs stay put under backpressure.
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                if (hold_pend[i]) begin
                    chk(i, "hold_valid", 128'(out_valid[i]), 128'd1);
                    chk(i, "hold_data", out_d[i], hold_val[i]);
                end
                if (out_valid[i] && out_ready[i]) begin
                    if (exp_q[i].size() == 0) chk(i, "extra_output", 128'(exp_q[i].size()), 128'd1);
                    else                      chk(i, "result", out_d[i], exp_q[i].pop_front());
                end
                hold_pend[i] = out_valid[i] && !out_ready[i];
                hold_val[i]  = out_d[i];
            end else begin
                hold_pend[i] = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [1919:0] k;
        build_tables();
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            in_valid[i] = 1'b0; mode[i] = 1'b0; st[i] = '0; key[i] = '0;
            out_ready[i] = 1'b1; bp_mode[i] = 0; stall_seen[i] = 1'b0;
            hold_pend[i] = 1'b0; hold_val[i] = '0; acc_cyc[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            chk(i, "reset_out_valid", 128'(out_valid[i]), 128'd0);
            chk(i, "reset_busy", 128'(busy[i]), 128'd0);
            chk(i, "reset_out", out_d[i], 128'd0);
        end
        rst = 1'b1;
        #1;
        for (int i = 0; i < N; i++) chk(i, "reset_in_ready", 128'(in_ready[i]), 128'd1);
        @(posedge clk); #1;

        // Known-answer vectors, including mode ignored when decrypt is absent.
        k = rand_key(); k[127:0] = c_B_RK;
        send(0, c_B_ST, 1'b0, k, c_B_EXP);
        wait_lat(0);
        k = rand_key(); k[1407 -: 128] = c_D_RK;
        send(0, c_D_ST, 1'b1, k, c_D_EXP);
        k = rand_key(); k[127:0] = c_C_RK;
        send(1, c_C_ST, 1'b0, k, c_C_EXP);
        wait_lat(1);
        k = rand_key(); k[127:0] = c_C_RK;
        send(2, c_C_ST, 1'b0, k, c_C_EXP);
        wait_lat(2);
        k = rand_key(); k[1919 -: 128] = c_D_RK;
        send(2, c_D_ST, 1'b1, k, c_D_EXP);
        k = rand_key(); k[127:0] = c_C_RK;
        send(3, c_C_ST, 1'b1, k, c_C_EXP);
        drain();

        // Eight back-to-back blocks with a four-cycle output stall.
        stall_seen[1] = 1'b0;
        bp_base       = cyc;
        bp_mode[1]    = 3;
        run_rand(1, 0);
        for (int j = 0; j < 8; j++) begin
            logic [127:0] s;
            logic         md;
            s  = rand_blk();
            k  = rand_key();
            md = $urandom_range(0, 1) == 1;
            send(1, s, md, k, ref_out(1, s, md, k));
        end
        drain();
        chk(1, "in_ready_stall", 128'(stall_seen[1]), 128'd1);
        chk(1, "stream_queue_empty", 128'(exp_q[1].size()), 128'd0);
        bp_mode[1] = 0;

        // Concurrent random traffic with random backpressure on every instance.
        for (int i = 0; i < N; i++) bp_mode[i] = 1;
        fork
            run_rand(0, 40);
            run_rand(1, 40);
            run_rand(2, 40);
            run_rand(3, 40);
        join
        for (int i = 0; i < N; i++) bp_mode[i] = 0;
        drain();

        // Reset with two blocks in flight and the output stalled.
        bp_mode[1] = 2;
        @(posedge clk); #1;
        out_ready[1] = 1'b0;
        for (int j = 0; j < 2; j++) begin
            logic [127:0] s;
            s = rand_blk();
            k = rand_key();
            send(1, s, 1'b0, k, ref_out(1, s, 1'b0, k));
        end
        repeat (3) @(posedge clk);
        #1;
        chk(1, "inflight_valid", 128'(out_valid[1]), 128'd1);
        #2 rst = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            chk(i, "async_rst_out_valid", 128'(out_valid[i]), 128'd0);
            chk(i, "async_rst_busy", 128'(busy[i]), 128'd0);
            chk(i, "async_rst_out", out_d[i], 128'd0);
            exp_q[i].delete();
        end
        @(posedge clk); #1;
        rst        = 1'b1;
        bp_mode[1] = 0;
        out_ready[1] = 1'b1;
        #1;
        chk(1, "post_rst_in_ready", 128'(in_ready[1]), 128'd1);
        k = rand_key(); k[127:0] = c_C_RK;
        send(1, c_C_ST, 1'b0, k, c_C_EXP);
        wait_lat(1);
        drain();

        for (int i = 0; i < N; i++) chk(i, "final_queue_empty", 128'(exp_q[i].size()), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
